// File: rtl/ntsc_cvbs_enc.sv
// ntsc_cvbs_enc
// Composite (CVBS) sample generator for NTSC at 4fsc.
// Takes unsigned 8-bit luma and two's-complement 8-bit U/V from the colour
// space converter. It modulates U/V onto a free-running 4-phase subcarrier
// and adds scaled luma. It also inserts the sync tip, blanking and colour
// burst levels from the timing-generator flags.
//
// Ports:
//   CK_i         clock (4fsc)
//   RST_i        synchronous reset, active-high
//   CK_EE_i      clock enable; every register holds when low (reset wins)
//   YYs_i        luma, unsigned 8-bit
//   UUs_i        U, signed 8-bit
//   VVs_i        V, signed 8-bit
//   SYNC_i       sync-tip interval flag
//   BURST_i      burst-gate interval flag
//   BLANK_i      blanking interval flag
//   PHASE_CLR_i  forces subcarrier phase 0 for the current sample
//   VIDEOs_o     10-bit unsigned composite sample
//   PHASE_o      subcarrier phase of the sample currently on VIDEOs_o
//
// The pipeline has two registered stages. The output reflects the inputs
// presented two enabled clocks earlier.

module ntsc_cvbs_enc #(
   parameter logic [9:0] C_SYNC  = 10'd16,
   parameter logic [9:0] C_BLANK = 10'd240,
   parameter logic [7:0] C_KY    = 8'd180,
   parameter logic [7:0] C_BURST = 8'd56
) (
   input  logic       CK_i,
   input  logic       RST_i,
   input  logic       CK_EE_i,
   input  logic [7:0] YYs_i,
   input  logic [7:0] UUs_i,
   input  logic [7:0] VVs_i,
   input  logic       SYNC_i,
   input  logic       BURST_i,
   input  logic       BLANK_i,
   input  logic       PHASE_CLR_i,
   output logic [9:0] VIDEOs_o,
   output logic [1:0] PHASE_o
);

   typedef enum logic [1:0] {
      MODE_ACTIVE,
      MODE_BLANK,
      MODE_BURST,
      MODE_SYNC
   } mode_t;

   logic [1:0]        ph;
   logic [1:0]        ph_use;

   mode_t             mode_next;
   logic [7:0]        luma_next;
   logic signed [8:0] c_next;
   logic signed [8:0] b_next;
   logic signed [8:0] u_half;
   logic signed [8:0] v_half;

   mode_t             s1_mode;
   logic [1:0]        s1_ph;
   logic [7:0]        s1_luma;
   logic signed [8:0] s1_c;
   logic signed [8:0] s1_b;

   logic signed [11:0] blank_ext;
   logic signed [11:0] sum_active;
   logic signed [11:0] sum_burst;
   logic [9:0]         video_next;

   // Clamp a signed intermediate into the DAC code range.
   function automatic logic [9:0] sat10(input logic signed [11:0] x);
      if (x < 12'sd0)
         return 10'd0;
      else if (x > 12'sd1023)
         return 10'd1023;
      else
         return x[9:0];
   endfunction

   // A phase clear applies to the sample being accepted now, not the next one.
   assign ph_use = PHASE_CLR_i ? 2'd0 : ph;

   // Stage-1 terms. The chroma half-amplitudes are formed on 9-bit
   // sign-extended values, so negating U=-128 yields +64 without overflow.
   always_comb begin
      mode_next = MODE_ACTIVE;
      if (SYNC_i)
         mode_next = MODE_SYNC;
      else if (BURST_i)
         mode_next = MODE_BURST;
      else if (BLANK_i)
         mode_next = MODE_BLANK;

      luma_next = 8'(({8'd0, YYs_i} * {8'd0, C_KY}) >> 8);

      u_half = $signed({UUs_i[7], UUs_i}) >>> 1;
      v_half = $signed({VVs_i[7], VVs_i}) >>> 1;

      c_next = 9'sd0;
      b_next = 9'sd0;
      case (ph_use)
         2'd0: begin
            c_next = u_half;
            b_next = -$signed({1'b0, C_BURST});
         end
         2'd1: c_next = v_half;
         2'd2: begin
            c_next = -u_half;
            b_next = $signed({1'b0, C_BURST});
         end
         default: c_next = -v_half;
      endcase
   end

   // Stage-2 output selection. The sums are formed in 12 bits, which leaves
   // headroom for any parameter override before saturation.
   always_comb begin
      blank_ext  = $signed({2'b00, C_BLANK});
      sum_active = blank_ext + $signed({4'b0000, s1_luma}) + 12'(s1_c);
      sum_burst  = blank_ext + 12'(s1_b);
      video_next = C_BLANK;
      case (s1_mode)
         MODE_SYNC:   video_next = C_SYNC;
         MODE_BURST:  video_next = sat10(sum_burst);
         MODE_BLANK:  video_next = C_BLANK;
         MODE_ACTIVE: video_next = sat10(sum_active);
         default:     video_next = C_BLANK;
      endcase
   end

   // The phase counter and both stages advance together on the enable.
   // Reset parks the pipeline in blanking at phase 0.
   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         ph       <= 2'd0;
         s1_mode  <= MODE_BLANK;
         s1_ph    <= 2'd0;
         s1_luma  <= 8'd0;
         s1_c     <= 9'sd0;
         s1_b     <= 9'sd0;
         VIDEOs_o <= C_BLANK;
         PHASE_o  <= 2'd0;
      end else if (CK_EE_i) begin
         ph       <= ph_use + 2'd1;
         s1_mode  <= mode_next;
         s1_ph    <= ph_use;
         s1_luma  <= luma_next;
         s1_c     <= c_next;
         s1_b     <= b_next;
         VIDEOs_o <= video_next;
         PHASE_o  <= s1_ph;
      end
   end

endmodule

// File: tb/tb_ntsc_cvbs_enc.sv
// tb_ntsc_cvbs_enc
// Directed bench for ntsc_cvbs_enc. Each accepted sample has its expected
// output pushed into a queue. The entry is popped once the pipeline delivers
// that sample.
//
// A second instance with C_BLANK=1000 shares the same stimulus. Its active
// samples are checked against the saturating model.

module tb_ntsc_cvbs_enc;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ce  = 1'b0;
   logic [7:0] yy  = 8'd0;
   logic [7:0] uu  = 8'd0;
   logic [7:0] vv  = 8'd0;
   logic       sync_f  = 1'b0;
   logic       burst_f = 1'b0;
   logic       blank_f = 1'b0;
   logic       clr     = 1'b0;
   logic [9:0] video;
   logic [1:0] phase;
   logic [9:0] video_sat;
   logic [1:0] phase_sat;

   typedef struct {
      logic [9:0] video;
      logic [9:0] video_sat;
      logic [1:0] phase;
      bit         active;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         mph = 0;
   logic [9:0] last_video = 10'd240;
   logic [1:0] last_phase = 2'd0;
   string      section = "init";

   always #5 clk = ~clk;

   ntsc_cvbs_enc dut (
      .CK_i(clk), .RST_i(rst), .CK_EE_i(ce),
      .YYs_i(yy), .UUs_i(uu), .VVs_i(vv),
      .SYNC_i(sync_f), .BURST_i(burst_f), .BLANK_i(blank_f),
      .PHASE_CLR_i(clr), .VIDEOs_o(video), .PHASE_o(phase)
   );

   ntsc_cvbs_enc #(.C_BLANK(10'd1000)) dut_sat (
      .CK_i(clk), .RST_i(rst), .CK_EE_i(ce),
      .YYs_i(yy), .UUs_i(uu), .VVs_i(vv),
      .SYNC_i(sync_f), .BURST_i(burst_f), .BLANK_i(blank_f),
      .PHASE_CLR_i(clr), .VIDEOs_o(video_sat), .PHASE_o(phase_sat)
   );

   // Reference composite level for one sample, in plain integer arithmetic.
   function automatic logic [9:0] model(input int blank, input int y, input int u,
                                        input int v, input bit s, input bit bu,
                                        input bit bl, input int ph);
      int r;
      int c;
      if (s) return 10'd16;
      if (bu) begin
         r = blank + ((ph == 0) ? -56 : (ph == 2) ? 56 : 0);
      end else if (bl) begin
         r = blank;
      end else begin
         case (ph)
            0: c = u >>> 1;
            1: c = v >>> 1;
            2: c = -(u >>> 1);
            default: c = -(v >>> 1);
         endcase
         r = blank + (y * 180) / 256 + c;
      end
      if (r < 0) r = 0;
      if (r > 1023) r = 1023;
      return 10'(r);
   endfunction

   // Compare outputs after a clock edge. On an enabled edge with two samples
   // queued, the oldest one is due. Otherwise the output must hold.
   task automatic checkOutput(input bit en);
      exp_t e;
      if (en && sb.size() >= 2) begin
         e = sb.pop_front();
         last_video = e.video;
         last_phase = e.phase;
         if (e.active) begin
            checks++;
            assert (video_sat === e.video_sat) else begin
               errors++;
               $error("[TB] FAIL %s sat video got %0d exp %0d", section, video_sat, e.video_sat);
            end
         end
      end
      checks++;
      assert (video === last_video) else begin
         errors++;
         $error("[TB] FAIL %s video got %0d exp %0d", section, video, last_video);
      end
      checks++;
      assert (phase === last_phase) else begin
         errors++;
         $error("[TB] FAIL %s phase got %0d exp %0d", section, phase, last_phase);
      end
   endtask

   // Drive one sample on the falling edge and queue its expectation if enabled.
   task automatic applyStimulus(input int y, input int u, input int v, input bit s,
                                input bit bu, input bit bl, input bit c, input bit en);
      exp_t e;
      int   pu;
      @(negedge clk);
      yy = 8'(y); uu = 8'(u); vv = 8'(v);
      sync_f = s; burst_f = bu; blank_f = bl; clr = c; ce = en;
      if (en) begin
         pu = c ? 0 : mph;
         e.video     = model(240, y, u, v, s, bu, bl, pu);
         e.video_sat = model(1000, y, u, v, s, bu, bl, pu);
         e.phase     = 2'(pu);
         e.active    = !(s || bu || bl);
         sb.push_back(e);
         mph = (pu + 1) % 4;
      end
      @(posedge clk);
      #1;
      checkOutput(en);
   endtask

   // Reset is held with the enable low to show that it overrides the enable.
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; ce = 1'b0; clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      mph = 0;
      last_video = 10'd240;
      last_phase = 2'd0;
      checkOutput(1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      section = "reset_hold";
      doReset();
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      section = "grey";
      repeat (8) applyStimulus(128, 0, 0, 0, 0, 0, 0, 1);

      section = "chroma";
      applyStimulus(0, 100, -40, 0, 0, 0, 1, 1);
      repeat (7) applyStimulus(0, 100, -40, 0, 0, 0, 0, 1);

      section = "burst";
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 1);
      repeat (7) applyStimulus(0, 0, 0, 0, 1, 1, 0, 1);

      section = "sync";
      repeat (4) applyStimulus(0, 0, 0, 1, 1, 1, 0, 1);

      section = "blank";
      repeat (2) applyStimulus(200, 50, 50, 0, 0, 1, 0, 1);

      section = "extremes";
      applyStimulus(255, -128, 0, 0, 0, 0, 1, 1);
      applyStimulus(255, -128, 0, 0, 0, 0, 0, 1);
      applyStimulus(255, -128, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 127, 0, 0, 0, 0, 1);
      applyStimulus(255, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(255, 0, 0, 0, 0, 0, 0, 1);

      section = "enable_gaps";
      for (int i = 0; i < 16; i++)
         applyStimulus(i * 15, 20, -20, 0, 0, 0, 0, (i % 4 == 0) || (i % 4 == 3));

      section = "drain";
      repeat (3) applyStimulus(128, 0, 0, 0, 0, 0, 0, 1);

      section = "midline_reset";
      doReset();
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) applyStimulus(64, 10, 10, 0, 0, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
